// File: rtl/neuron_layer_pkg.sv
// Shared types and constants for the neuron layer sequencer.
package neuron_layer_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default widths shared with the serial MAC
    localparam int unsigned DEF_X_W   = 8;
    localparam int unsigned DEF_W_W   = 8;
    localparam int unsigned DEF_B_W   = 32;
    localparam int unsigned DEF_OUT_W = 16;

    // Ceiling log2 for elaboration-time sizing
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned t;
        r = 0;
        t = 1;
        while (t < v) begin
            t = t << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_weight_bank.sv
// Per-neuron {bias, weight row} storage: one sync write port, one comb read port.
module neuron_weight_bank
    import neuron_layer_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned W_W         = DEF_W_W,
    parameter int unsigned B_W         = DEF_B_W,
    localparam int unsigned NIDX_W     = (NUM_NEURONS > 1) ? clog2(NUM_NEURONS) : 1,
    localparam int unsigned ROW_W      = NUM_INPUTS * W_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [NIDX_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]  wr_w,
    input  logic [B_W-1:0]    wr_bias,
    input  logic [NIDX_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  rd_w,
    output logic [B_W-1:0]    rd_bias
);

    logic [ROW_W-1:0] w_q [NUM_NEURONS];
    logic [B_W-1:0]   b_q [NUM_NEURONS];
    logic             addr_ok;

    // Writes to addresses beyond the last neuron are dropped
    if ((2 ** NIDX_W) == NUM_NEURONS) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (32'(wr_addr) < NUM_NEURONS);
    end

    // Row storage with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                w_q[NIDX_W'(i)] <= '0;
                b_q[NIDX_W'(i)] <= '0;
            end
        end else if (wr_en && addr_ok) begin
            w_q[wr_addr] <= wr_w;
            b_q[wr_addr] <= wr_bias;
        end
    end

    assign rd_w    = w_q[rd_addr];
    assign rd_bias = b_q[rd_addr];

endmodule

// File: rtl/neuron_layer_seq.sv
// Layer sequencer: feeds one serial MAC per neuron and assembles the layer result.
// Optional macro NEURON_LAYER_SEQ_TIMEOUT_EN enables the WAIT-state watchdog.
module neuron_layer_seq
    import neuron_layer_pkg::*;
#(
    parameter int unsigned NUM_INPUTS     = 8,
    parameter int unsigned NUM_NEURONS    = 4,
    parameter int unsigned X_W            = DEF_X_W,
    parameter int unsigned W_W            = DEF_W_W,
    parameter int unsigned B_W            = DEF_B_W,
    parameter int unsigned OUT_W          = DEF_OUT_W,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned NIDX_W        = (NUM_NEURONS > 1) ? clog2(NUM_NEURONS) : 1,
    localparam int unsigned XV_W          = NUM_INPUTS * X_W,
    localparam int unsigned WV_W          = NUM_INPUTS * W_W,
    localparam int unsigned RES_W         = NUM_NEURONS * OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wload_valid,
    output logic              wload_ready,
    input  logic [NIDX_W-1:0] wload_addr,
    input  logic [WV_W-1:0]   wload_w,
    input  logic [B_W-1:0]    wload_bias,
    input  logic              vec_valid,
    output logic              vec_ready,
    input  logic [XV_W-1:0]   vec_x,
    output logic              mac_in_valid,
    input  logic              mac_in_ready,
    output logic [B_W-1:0]    mac_bias,
    output logic [XV_W-1:0]   mac_x_flat,
    output logic [WV_W-1:0]   mac_w_flat,
    input  logic              mac_out_valid,
    input  logic [OUT_W-1:0]  mac_out_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic              err_timeout
);

    state_t            state_q, state_d;
    logic [NIDX_W-1:0] n_q, n_d;
    logic [XV_W-1:0]   x_q;
    logic [RES_W-1:0]  res_q;
    logic              x_load;
    logic              slot_we;
    logic [OUT_W-1:0]  slot_data;
    logic              timeout_hit;
    logic              last_neuron;

    assign last_neuron = (n_q == NIDX_W'(NUM_NEURONS - 1));

    neuron_weight_bank #(
        .NUM_INPUTS  (NUM_INPUTS),
        .NUM_NEURONS (NUM_NEURONS),
        .W_W         (W_W),
        .B_W         (B_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wload_valid && (state_q == ST_IDLE)),
        .wr_addr (wload_addr),
        .wr_w    (wload_w),
        .wr_bias (wload_bias),
        .rd_addr (n_q),
        .rd_w    (mac_w_flat),
        .rd_bias (mac_bias)
    );

`ifdef NEURON_LAYER_SEQ_TIMEOUT_EN
    localparam int unsigned TCNT_W = clog2(TIMEOUT_CYCLES) + 1;

    logic [TCNT_W-1:0] wait_cnt_q;
    logic              err_q;

    // A WAIT cycle that would be the TIMEOUT_CYCLES-th without a result fires the watchdog
    assign timeout_hit = (state_q == ST_WAIT) && !mac_out_valid &&
                         (wait_cnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter (zero outside WAIT) and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q != ST_WAIT) begin
                wait_cnt_q <= '0;
            end else if (!mac_out_valid) begin
                wait_cnt_q <= wait_cnt_q + TCNT_W'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        x_load    = 1'b0;
        slot_we   = 1'b0;
        slot_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (vec_valid) begin
                    x_load  = 1'b1;
                    n_d     = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mac_in_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mac_out_valid || timeout_hit) begin
                    slot_we   = 1'b1;
                    slot_data = mac_out_valid ? mac_out_data : '0;
                    if (last_neuron) begin
                        state_d = ST_DONE;
                    end else begin
                        n_d     = n_q + NIDX_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, neuron index, activation latch and result slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            x_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            if (x_load) begin
                x_q <= vec_x;
            end
            if (slot_we) begin
                res_q[n_q*OUT_W +: OUT_W] <= slot_data;
            end
        end
    end

    assign wload_ready  = (state_q == ST_IDLE);
    assign vec_ready    = (state_q == ST_IDLE);
    assign mac_in_valid = (state_q == ST_ISSUE);
    assign res_valid    = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign mac_x_flat   = x_q;
    assign res_data     = res_q;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq with a behavioural serial MAC (ReLU, OUT_FRAC=8).
// Define NEURON_LAYER_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_neuron_layer_seq;

    localparam int NI    = 8;
    localparam int NN    = 4;
    localparam int OUT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wload_valid;
    logic              wload_ready;
    logic [1:0]        wload_addr;
    logic [NI*8-1:0]   wload_w;
    logic [31:0]       wload_bias;
    logic              vec_valid;
    logic              vec_ready;
    logic [NI*8-1:0]   vec_x;
    logic              mac_in_valid;
    logic              mac_in_ready;
    logic [31:0]       mac_bias;
    logic [NI*8-1:0]   mac_x_flat;
    logic [NI*8-1:0]   mac_w_flat;
    logic              mac_out_valid;
    logic [OUT_W-1:0]  mac_out_data;
    logic              res_valid;
    logic              res_ready;
    logic [NN*OUT_W-1:0] res_data;
    logic              busy;
    logic              err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_layer_seq dut (
        .clk           (clk),
        .rst           (rst),
        .wload_valid   (wload_valid),
        .wload_ready   (wload_ready),
        .wload_addr    (wload_addr),
        .wload_w       (wload_w),
        .wload_bias    (wload_bias),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .vec_x         (vec_x),
        .mac_in_valid  (mac_in_valid),
        .mac_in_ready  (mac_in_ready),
        .mac_bias      (mac_bias),
        .mac_x_flat    (mac_x_flat),
        .mac_w_flat    (mac_w_flat),
        .mac_out_valid (mac_out_valid),
        .mac_out_data  (mac_out_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    // Behavioural MAC: result pulse NUM_INPUTS+1 cycles after the handshake
    bit          hold_ready;
    bit          spur_valid;
    logic [15:0] spur_data;
    int          drop_idx;
    bit          mac_busy;
    bit          mac_pulse;
    bit          mac_drop;
    int          mac_cnt;
    int          req_num;
    logic [15:0] mac_res;

    function automatic logic [15:0] mac_calc(input logic [63:0] xf, input logic [63:0] wf,
                                             input logic [31:0] b);
        longint acc;
        logic signed [7:0] xs;
        logic signed [7:0] ws;
        acc = longint'($signed(b));
        for (int i = 0; i < NI; i++) begin
            xs = xf[i*8 +: 8];
            ws = wf[i*8 +: 8];
            acc += longint'(xs) * longint'(ws);
        end
        if (acc < 0) acc = 0;
        if (acc > 32767) acc = 32767;
        return 16'(acc);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_busy  <= 1'b0;
            mac_pulse <= 1'b0;
            mac_drop  <= 1'b0;
            mac_cnt   <= 0;
            req_num   <= 0;
            mac_res   <= '0;
        end else begin
            mac_pulse <= 1'b0;
            if (mac_in_valid && mac_in_ready) begin
                mac_busy <= 1'b1;
                mac_cnt  <= 0;
                mac_res  <= mac_calc(mac_x_flat, mac_w_flat, mac_bias);
                mac_drop <= (req_num == drop_idx);
                req_num  <= req_num + 1;
            end else if (mac_busy) begin
                if (mac_cnt == NI - 1) begin
                    mac_busy  <= 1'b0;
                    mac_pulse <= !mac_drop;
                end else begin
                    mac_cnt <= mac_cnt + 1;
                end
            end
        end
    end

    assign mac_in_ready  = !mac_busy && !hold_ready;
    assign mac_out_valid = mac_pulse | spur_valid;
    assign mac_out_data  = spur_valid ? spur_data : mac_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_row(input logic [1:0] a, input logic [7:0] wb, input logic [31:0] b);
        wload_valid = 1'b1;
        wload_addr  = a;
        wload_w     = {NI{wb}};
        wload_bias  = b;
        @(posedge clk); #1;
        wload_valid = 1'b0;
    endtask

    // Present a vector (cycle 0) and return the cycle in which res_valid is first seen
    task automatic run_vector(input logic [7:0] xb, output int cyc);
        vec_x     = {NI{xb}};
        vec_valid = 1'b1;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench stopped");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        wload_valid = 1'b0; wload_addr = '0; wload_w = '0; wload_bias = '0;
        vec_valid = 1'b0; vec_x = '0; res_ready = 1'b1;
        hold_ready = 1'b0; spur_valid = 1'b0; spur_data = '0; drop_idx = -1;
        #23;
        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vec_ready", 64'(vec_ready), 64'd1);
        chk("rst_wload_ready", 64'(wload_ready), 64'd1);
        chk("rst_mac_in_valid", 64'(mac_in_valid), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_err_timeout", 64'(err_timeout), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_mac_w", mac_w_flat, 64'd0);
        chk("rst_mac_x", mac_x_flat, 64'd0);
        chk("rst_mac_bias", 64'(mac_bias), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: all weights 1.0, x all 1.0 -> 8.0 per neuron, result in cycle 41
        for (int i = 0; i < NN; i++) load_row(2'(i), 8'h10, 32'h0);
        vec_x = {NI{8'h10}};
        vec_valid = 1'b1;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        chk("t1_issue_cycle1", 64'(mac_in_valid), 64'd1);
        chk("t1_vec_ready_busy", 64'(vec_ready), 64'd0);
        chk("t1_wload_ready_busy", 64'(wload_ready), 64'd0);
        cyc = 1;
        while (!res_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t1_latency", 64'(cyc), 64'd41);
        chk("t1_res_data", res_data, 64'h0800_0800_0800_0800);
        @(posedge clk); #1;
        chk("t1_back_idle", 64'(busy), 64'd0);

        // Test 2: row 2 weights -1.0 (ReLU -> 0), downstream stalls 5 cycles
        load_row(2'd2, 8'hF0, 32'h0);
        res_ready = 1'b0;
        run_vector(8'h10, cyc);
        chk("t2_latency", 64'(cyc), 64'd41);
        for (int k = 0; k < 5; k++) begin
            chk("t2_stall_valid", 64'(res_valid), 64'd1);
            chk("t2_stall_data", res_data, 64'h0800_0000_0800_0800);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_release_idle", 64'(busy), 64'd0);
        chk("t2_release_valid", 64'(res_valid), 64'd0);

        // Test 3: row write and vector accepted in the same cycle
        wload_valid = 1'b1; wload_addr = 2'd0; wload_w = '0; wload_bias = 32'h0000_0100;
        vec_x = '0; vec_valid = 1'b1;
        @(posedge clk); #1;
        wload_valid = 1'b0; vec_valid = 1'b0;
        chk("t3_issue_bias", 64'(mac_bias), 64'h100);
        cyc = 1;
        while (!res_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t3_res_data", res_data, 64'h0000_0000_0000_0100);
        @(posedge clk); #1;

        // Test 4: MAC not ready for 10 cycles in ISSUE; request data must hold
        load_row(2'd0, 8'h20, 32'h0000_0200);
        hold_ready = 1'b1;
        vec_x = {NI{8'h08}};
        vec_valid = 1'b1;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t4_hold_valid", 64'(mac_in_valid), 64'd1);
            chk("t4_hold_x", mac_x_flat, 64'h0808_0808_0808_0808);
            chk("t4_hold_w", mac_w_flat, 64'h2020_2020_2020_2020);
            chk("t4_hold_bias", 64'(mac_bias), 64'h200);
            @(posedge clk); #1;
        end
        hold_ready = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t4_res_data", res_data, 64'h0400_0000_0400_0A00);
        @(posedge clk); #1;
        chk("t4_idle", 64'(busy), 64'd0);
        spur_data = 16'h1234; spur_valid = 1'b1;
        @(posedge clk); #1;
        spur_valid = 1'b0;
        @(posedge clk); #1;
        chk("t4_spurious_ignored", res_data, 64'h0400_0000_0400_0A00);
        chk("t4_spurious_idle", 64'(busy), 64'd0);

        // Test 5: reset during WAIT of neuron 1
        vec_x = {NI{8'h10}};
        vec_valid = 1'b1;
        @(posedge clk); #1;
        vec_valid = 1'b0;
        repeat (13) begin
            @(posedge clk); #1;
        end
        chk("t5_busy_in_wait", 64'(busy), 64'd1);
        chk("t5_wait_no_req", 64'(mac_in_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_vec_ready", 64'(vec_ready), 64'd1);
        chk("t5_rst_res_data", res_data, 64'd0);
        chk("t5_rst_weights", mac_w_flat, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vector(8'h10, cyc);
        chk("t5_fresh_latency", 64'(cyc), 64'd41);
        chk("t5_fresh_res", res_data, 64'd0);
        @(posedge clk); #1;
        chk("t5_err_timeout", 64'(err_timeout), 64'd0);

`ifdef NEURON_LAYER_SEQ_TIMEOUT_EN
        // Test 6: MAC never answers neuron 3; watchdog fills slot 3 with 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NN; i++) load_row(2'(i), 8'h10, 32'h0);
        drop_idx = 3;
        run_vector(8'h10, cyc);
        chk("t6_latency", 64'(cyc), 64'd96);
        chk("t6_res_data", res_data, 64'h0000_0800_0800_0800);
        chk("t6_err_set", 64'(err_timeout), 64'd1);
        @(posedge clk); #1;
        chk("t6_idle", 64'(busy), 64'd0);
        chk("t6_err_sticky", 64'(err_timeout), 64'd1);
        drop_idx = -1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
